uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 15360000, system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 614400, line rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 8, ticks per bit; power of 2, 4..16.
REQ-004 SHALL have parameter DATA_BITS, default 8, payload width; 5..9.
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked; 1 or 2.
REQ-007 SHALL have parameter GAP_BITS, default 2, idle bit-times that end a packet; 1..15.
REQ-008 SHALL have port clk, input, 1, single clock; one clock, all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-010 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-011 SHALL have port rx_data, output, DATA_BITS, last received payload, LSB received first.
REQ-012 SHALL have port rx_valid, output, 1, one-cycle pulse when a frame completes.
REQ-013 SHALL have port parity_err, output, 1, pulse coincident with rx_valid on parity mismatch.
REQ-014 SHALL have port frame_err, output, 1, pulse coincident with rx_valid when any stop bit reads 0.
REQ-015 SHALL have port break_det, output, 1, one-cycle pulse on a detected break.
REQ-016 SHALL have port rx_idle, output, 1, high while the line has been idle for at least GAP_BITS bit-times.
REQ-017 SHALL have port rx_eop, output, 1, one-cycle end-of-packet pulse.

Function
REQ-018 SHALL generate os_tick at BAUD*OVERSAMPLE with a fractional accumulator; long-term rate error below 0.1%.
REQ-019 SHALL synchronise rx through two flops clocked on os_tick, reset to 1.
REQ-020 SHALL filter the synchronised line as a 3-sample majority (rx_bit), updated on os_tick.
REQ-021 SHALL run FSM states IDLE, START, DATA, PARITY, STOP, BREAK; PARITY is skipped when PARITY=0.
REQ-022 IDLE->START SHALL occur on rx_bit=0; the os_tick phase counter is cleared at that point.
REQ-023 In START, rx_bit SHALL be resampled after OVERSAMPLE/2 ticks; if 1, go to IDLE (false start) with no outputs.
REQ-024 Every later bit SHALL be sampled exactly OVERSAMPLE ticks after the previous sample (mid-bit).
REQ-025 DATA SHALL shift DATA_BITS samples LSB-first into an internal register; rx_data updates only when rx_valid pulses and otherwise holds.
REQ-026 Parity SHALL be XOR of the data bits and parity bit, must be 0 for even and 1 for odd; a mismatch raises parity_err.
REQ-027 STOP SHALL sample STOP_BITS bits; any 0 sets frame_err, but sampling continues for all stop bits.
REQ-028 After the last stop sample, registered rx_valid SHALL assert on the following clk cycle for exactly 1 cycle.
REQ-029 A break SHALL be all data, parity and first stop samples = 0: break_det pulses, rx_valid does not, and the FSM enters BREAK.
REQ-030 BREAK SHALL exit to IDLE only after rx_bit=1 is seen for one full bit-time.
REQ-031 A new start edge SHALL be accepted in IDLE on the first os_tick after the stop sample, with no dead time.
REQ-032 The gap counter SHALL count os_ticks only in IDLE, saturating at GAP_BITS*OVERSAMPLE, and SHALL clear on leaving IDLE.
REQ-033 rx_idle SHALL equal (gap counter saturated).
REQ-034 rx_eop SHALL pulse once in the cycle the counter saturates, only if at least one rx_valid occurred since the previous rx_eop or reset.

Reset
REQ-035 Reset SHALL drive:
- FSM to IDLE;
- synchroniser and filter to 1;
- rx_data, rx_valid, parity_err, frame_err, break_det and rx_eop to 0;
- the gap counter to saturated (rx_idle=1);
- the packet-pending flag to 0.
REQ-036 Reset mid-frame SHALL discard the partial frame with no pulse outputs, during or after reset.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the parity-mode constants (NONE/EVEN/ODD), and an elaboration check that CLK_FREQ >= 2*BAUD*OVERSAMPLE.
REQ-038 The tick generator SHALL be one sub-module, uart_os_tick_gen (parameters CLK_FREQ, RATE; ports clk, rst, tick); all else stays in uart_rx_param.

Verification
REQ-039 Defaults, byte 0xA5 at 614400 baud -> one rx_valid, rx_data=0xA5, no error pulses, then rx_eop once after 2 bit-times idle.
REQ-040 DATA_BITS=7, PARITY=1, STOP_BITS=2, 0x55 sent with wrong parity bit -> rx_valid with rx_data=0x55 and parity_err=1; second stop bit forced 0 -> frame_err=1.
REQ-041 Low glitch of 1 os_tick period, then a 0.4-bit low pulse -> no state change, then a false start, with no rx_valid in either case.
REQ-042 rx held low 12 bit-times -> exactly one break_det, no rx_valid; after rx returns high, a following 0x3C is received correctly.
REQ-043 Three back-to-back bytes 0x01,0x02,0x03 with no gap, at BAUD +2% -> three rx_valid in order, rx_idle low throughout, a single rx_eop at the end.
REQ-044 rst asserted at data bit 4 of a frame -> no rx_valid, rx_idle=1, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// parity-mode constants and the parameter sanity check used at elaboration.
package uart_rx_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // The tick generator needs at least two clocks per oversample tick.
    function automatic bit rate_ok(input longint clk_freq, input longint baud,
                                   input longint oversample);
        return clk_freq >= 2 * baud * oversample;
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Fractional-accumulator tick generator: one-cycle tick at an average rate of
// RATE per second from a CLK_FREQ clock, with no long-term drift.
module uart_os_tick_gen
    import uart_rx_param_pkg::*;
#(
    parameter int CLK_FREQ = 15360000,
    parameter int RATE     = 4915200
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int ACC_W = $clog2(CLK_FREQ) + 2;
    localparam logic [ACC_W-1:0] STEP = ACC_W'(RATE);
    localparam logic [ACC_W-1:0] WRAP = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             tick_q, tick_d;

    always_comb begin
        sum    = acc_q + STEP;
        acc_d  = sum;
        tick_d = 1'b0;
        if (sum >= WRAP) begin
            acc_d  = sum - WRAP;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority filter, parity/framing/break
// detection and idle-gap based end-of-packet signalling.
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int CLK_FREQ   = 15360000,
    parameter int BAUD       = 614400,
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 rx_idle,
    output logic                 rx_eop
);

    localparam int PH_W    = $clog2(OVERSAMPLE);
    localparam int HALF    = OVERSAMPLE / 2;
    localparam int GAP_MAX = GAP_BITS * OVERSAMPLE;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    if (!rate_ok(CLK_FREQ, BAUD, OVERSAMPLE)) begin : g_bad_rate
        $error("uart_rx_param: CLK_FREQ must be at least 2*BAUD*OVERSAMPLE");
    end
    if ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0 || OVERSAMPLE < 4 || OVERSAMPLE > 16 ||
        DATA_BITS < 5 || DATA_BITS > 9 || PARITY > PAR_ODD ||
        STOP_BITS < 1 || STOP_BITS > 2 || GAP_BITS < 1 || GAP_BITS > 15) begin : g_bad_param
        $error("uart_rx_param: parameter out of range");
    end

    logic tick;

    uart_os_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .RATE     (BAUD * OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    rx_state_t            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           win_q, win_d;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 stop_q, stop_d;
    logic                 ferr_q, ferr_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 pend_q, pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q, break_d;
    logic                 eop_q, eop_d;
    logic                 rx_bit;
    logic                 bit_due;
    logic                 par_calc;

    // Majority of the newest synchronised sample and the two before it.
    assign rx_bit = (sync_q[1] & win_q[0]) | (sync_q[1] & win_q[1]) | (win_q[0] & win_q[1]);
    assign bit_due  = (ph_q == PH_W'(OVERSAMPLE - 1));
    assign par_calc = (^shreg_q) ^ par_q;

    always_comb begin
        state_d      = state_q;
        sync_d       = sync_q;
        win_d        = win_q;
        ph_d         = ph_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        stop_d       = stop_q;
        ferr_d       = ferr_q;
        gap_d        = gap_q;
        pend_d       = pend_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        break_d      = 1'b0;
        eop_d        = 1'b0;

        if (tick) begin
            sync_d = {sync_q[0], rx};
            win_d  = {win_q[0], sync_q[1]};
            ph_d   = ph_q + 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state_d = ST_START;
                        ph_d    = '0;
                    end
                end
                ST_START: begin
                    if (ph_q == PH_W'(HALF - 1)) begin
                        ph_d    = '0;
                        bit_d   = '0;
                        par_d   = 1'b0;
                        state_d = rx_bit ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_due) begin
                        shreg_d = {rx_bit, shreg_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                            stop_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_due) begin
                        par_d   = rx_bit;
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_due) begin
                        if (!stop_q && !rx_bit && shreg_q == '0 && !par_q) begin
                            break_d = 1'b1;
                            ph_d    = '0;
                            state_d = ST_BREAK;
                        end else if (stop_q == 1'(STOP_BITS - 1)) begin
                            state_d      = ST_IDLE;
                            rx_valid_d   = 1'b1;
                            rx_data_d    = shreg_q;
                            frame_err_d  = ferr_q | ~rx_bit;
                            parity_err_d = (PARITY != PAR_NONE) &&
                                           (par_calc != (PARITY == PAR_ODD));
                        end else begin
                            stop_d = 1'b1;
                            ferr_d = ferr_q | ~rx_bit;
                        end
                    end
                end
                ST_BREAK: begin
                    // Leave only after a full bit-time of continuous mark.
                    if (!rx_bit) begin
                        ph_d = '0;
                    end else if (bit_due) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_q != ST_IDLE || state_d != ST_IDLE) begin
            gap_d = '0;
        end else if (tick && gap_q != GAP_W'(GAP_MAX)) begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_W'(GAP_MAX - 1) && pend_q) begin
                eop_d  = 1'b1;
                pend_d = 1'b0;
            end
        end

        if (rx_valid_d) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync_q       <= 2'b11;
            win_q        <= 2'b11;
            ph_q         <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            ferr_q       <= 1'b0;
            gap_q        <= GAP_W'(GAP_MAX);
            pend_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            win_q        <= win_d;
            ph_q         <= ph_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            stop_q       <= stop_d;
            ferr_q       <= ferr_d;
            gap_q        <= gap_d;
            pend_q       <= pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_q      <= break_d;
            eop_q        <= eop_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_q;
    assign rx_idle    = (gap_q == GAP_W'(GAP_MAX));
    assign rx_eop     = eop_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a default 8N1 receiver and a 7E2 receiver
// driven from one linear stimulus sequence, with pulses logged by a monitor.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam real BIT_NS  = 250.0;          // 15.36 MHz / 614400 = 25 clocks
    localparam real FAST_NS = 250.0 / 1.02;   // BAUD +2%

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;

    logic [7:0] a_data;
    logic       a_vld, a_perr_o, a_ferr_o, a_brk_o, a_idle_o, a_eop_o;
    logic [6:0] b_data;
    logic       b_vld, b_perr_o, b_ferr_o, b_brk_o, b_idle_o, b_eop_o;

    always #5 clk = ~clk;

    uart_rx_param u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_a),
        .rx_data    (a_data),
        .rx_valid   (a_vld),
        .parity_err (a_perr_o),
        .frame_err  (a_ferr_o),
        .break_det  (a_brk_o),
        .rx_idle    (a_idle_o),
        .rx_eop     (a_eop_o)
    );

    uart_rx_param #(
        .DATA_BITS (7),
        .PARITY    (1),
        .STOP_BITS (2)
    ) u_dut7 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_b),
        .rx_data    (b_data),
        .rx_valid   (b_vld),
        .parity_err (b_perr_o),
        .frame_err  (b_ferr_o),
        .break_det  (b_brk_o),
        .rx_idle    (b_idle_o),
        .rx_eop     (b_eop_o)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Pulse monitor: counts every high cycle so a stretched pulse is visible.
    int         a_valid = 0, a_perr = 0, a_ferr = 0, a_brk = 0, a_eop = 0;
    int         a_idle_low = 0, a_idle_hi_watch = 0;
    int         b_valid = 0, b_brk = 0;
    logic [7:0] a_log [0:63];
    logic [6:0] b_log_data [0:63];
    logic       b_log_perr [0:63];
    logic       b_log_ferr [0:63];
    logic       watch_idle = 1'b0;

    always @(negedge clk) begin
        if (a_vld) begin
            a_log[a_valid & 63] <= a_data;
            a_valid <= a_valid + 1;
        end
        if (a_perr_o) a_perr <= a_perr + 1;
        if (a_ferr_o) a_ferr <= a_ferr + 1;
        if (a_brk_o)  a_brk  <= a_brk + 1;
        if (a_eop_o)  a_eop  <= a_eop + 1;
        if (!a_idle_o) a_idle_low <= a_idle_low + 1;
        if (watch_idle && a_idle_o) a_idle_hi_watch <= a_idle_hi_watch + 1;
        if (b_vld) begin
            b_log_data[b_valid & 63] <= b_data;
            b_log_perr[b_valid & 63] <= b_perr_o;
            b_log_ferr[b_valid & 63] <= b_ferr_o;
            b_valid <= b_valid + 1;
        end
        if (b_brk_o) b_brk <= b_brk + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel_b, input logic v, input real dur);
        if (sel_b) rx_b = v;
        else       rx_a = v;
        #(dur);
    endtask

    task automatic send_a(input logic [7:0] d, input real bit_ns);
        drive(1'b0, 1'b0, bit_ns);
        for (int i = 0; i < 8; i++) drive(1'b0, d[i], bit_ns);
        drive(1'b0, 1'b1, bit_ns);
    endtask

    task automatic send_b(input logic [6:0] d, input logic pbit, input logic stop2);
        drive(1'b1, 1'b0, BIT_NS);
        for (int i = 0; i < 7; i++) drive(1'b1, d[i], BIT_NS);
        drive(1'b1, pbit, BIT_NS);
        drive(1'b1, 1'b1, BIT_NS);
        drive(1'b1, stop2, BIT_NS);
        rx_b = 1'b1;
    endtask

    int s_valid, s_perr, s_ferr, s_brk, s_eop, s_low, b_idx;

    task automatic snap();
        s_valid = a_valid;
        s_perr  = a_perr;
        s_ferr  = a_ferr;
        s_brk   = a_brk;
        s_eop   = a_eop;
        s_low   = a_idle_low;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data",  32'(a_data), 32'h0);
        check("rst_rx_valid", 32'(a_vld), 32'h0);
        check("rst_rx_idle",  32'(a_idle_o), 32'h1);
        check("rst_errs",     32'({a_perr_o, a_ferr_o, a_brk_o, a_eop_o}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #(4.0 * BIT_NS);

        // 0xA5 on the default receiver, then idle for end-of-packet
        snap();
        send_a(8'hA5, BIT_NS);
        #(3.0 * BIT_NS);
        check("a5_valid_cnt", 32'(a_valid - s_valid), 32'd1);
        check("a5_data",      32'(a_log[s_valid & 63]), 32'hA5);
        check("a5_held_data", 32'(a_data), 32'hA5);
        check("a5_perr_cnt",  32'(a_perr - s_perr), 32'd0);
        check("a5_ferr_cnt",  32'(a_ferr - s_ferr), 32'd0);
        check("a5_eop_cnt",   32'(a_eop - s_eop), 32'd1);
        check("a5_idle",      32'(a_idle_o), 32'h1);

        // 7E2 receiver: wrong parity bit, then good parity with second stop low
        b_idx = b_valid;
        send_b(7'h55, 1'b1, 1'b1);
        #(2.0 * BIT_NS);
        check("b_par_valid_cnt", 32'(b_valid - b_idx), 32'd1);
        check("b_par_data",      32'(b_log_data[b_idx & 63]), 32'h55);
        check("b_par_perr",      32'(b_log_perr[b_idx & 63]), 32'h1);
        check("b_par_ferr",      32'(b_log_ferr[b_idx & 63]), 32'h0);
        b_idx = b_valid;
        send_b(7'h55, 1'b0, 1'b0);
        #(3.0 * BIT_NS);
        check("b_stop_valid_seen", 32'(b_valid > b_idx), 32'h1);
        check("b_stop_data",       32'(b_log_data[b_idx & 63]), 32'h55);
        check("b_stop_perr",       32'(b_log_perr[b_idx & 63]), 32'h0);
        check("b_stop_ferr",       32'(b_log_ferr[b_idx & 63]), 32'h1);
        check("b_no_break",        32'(b_brk), 32'd0);

        // Glitch shorter than one os_tick period: must not leave IDLE
        snap();
        @(posedge clk);
        #2;
        rx_a = 1'b0;
        #30;
        rx_a = 1'b1;
        #(3.0 * BIT_NS);
        check("glitch_idle_low", 32'(a_idle_low - s_low), 32'd0);
        check("glitch_valid",    32'(a_valid - s_valid), 32'd0);

        // 0.4-bit low pulse: false start, back to idle without outputs
        snap();
        rx_a = 1'b0;
        #(0.4 * BIT_NS);
        rx_a = 1'b1;
        #(4.0 * BIT_NS);
        check("fstart_left_idle", 32'(a_idle_low != s_low), 32'h1);
        check("fstart_valid",     32'(a_valid - s_valid), 32'd0);
        check("fstart_break",     32'(a_brk - s_brk), 32'd0);
        check("fstart_eop",       32'(a_eop - s_eop), 32'd0);
        check("fstart_idle",      32'(a_idle_o), 32'h1);

        // Break: 12 bit-times low, then a normal 0x3C
        snap();
        rx_a = 1'b0;
        #(12.0 * BIT_NS);
        rx_a = 1'b1;
        #(3.0 * BIT_NS);
        check("brk_cnt",   32'(a_brk - s_brk), 32'd1);
        check("brk_valid", 32'(a_valid - s_valid), 32'd0);
        send_a(8'h3C, BIT_NS);
        #(3.0 * BIT_NS);
        check("brk_3c_valid", 32'(a_valid - s_valid), 32'd1);
        check("brk_3c_data",  32'(a_log[s_valid & 63]), 32'h3C);
        check("brk_3c_ferr",  32'(a_ferr - s_ferr), 32'd0);
        check("brk_eop_cnt",  32'(a_eop - s_eop), 32'd1);

        // Three back-to-back bytes at +2% baud
        snap();
        fork
            begin
                send_a(8'h01, FAST_NS);
                send_a(8'h02, FAST_NS);
                send_a(8'h03, FAST_NS);
            end
            begin
                #(2.0 * FAST_NS);
                watch_idle = 1'b1;
                #(27.5 * FAST_NS);
                watch_idle = 1'b0;
            end
        join
        #(3.0 * BIT_NS);
        check("b2b_valid_cnt", 32'(a_valid - s_valid), 32'd3);
        check("b2b_data0",     32'(a_log[s_valid & 63]), 32'h01);
        check("b2b_data1",     32'(a_log[(s_valid + 1) & 63]), 32'h02);
        check("b2b_data2",     32'(a_log[(s_valid + 2) & 63]), 32'h03);
        check("b2b_idle_high", 32'(a_idle_hi_watch), 32'd0);
        check("b2b_ferr_cnt",  32'(a_ferr - s_ferr), 32'd0);
        check("b2b_eop_cnt",   32'(a_eop - s_eop), 32'd1);

        // Reset in the middle of data bit 4, then a clean frame
        snap();
        drive(1'b0, 1'b0, BIT_NS);
        for (int i = 0; i < 4; i++) drive(1'b0, i[0], BIT_NS);
        drive(1'b0, 1'b0, 0.5 * BIT_NS);
        rst = 1'b1;
        #20;
        rx_a = 1'b1;
        #1;
        check("midrst_rx_data", 32'(a_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_idle", 32'(a_idle_o), 32'h1);
        #(4.0 * BIT_NS);
        check("midrst_valid", 32'(a_valid - s_valid), 32'd0);
        check("midrst_pulses", 32'((a_brk - s_brk) + (a_eop - s_eop) + (a_ferr - s_ferr)), 32'd0);
        send_a(8'h96, BIT_NS);
        #(3.0 * BIT_NS);
        check("midrst_next_valid", 32'(a_valid - s_valid), 32'd1);
        check("midrst_next_data",  32'(a_log[s_valid & 63]), 32'h96);
        check("midrst_next_eop",   32'(a_eop - s_eop), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
